// File: rtl/lsu_pkg.sv
// Shared types and helpers for the dmem load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_e;

  // Size code 3 is illegal and is reported through the same error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return addr_lo[0];
      2'd2:    return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core request/response and dmem bus bundle; slave is the LSU view, master the environment view.
interface dmem_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane datapath: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = word >> {addr_lo, 3'b000};
    load_data = shifted;
    case (size_e'(size))
      SIZE_B:  load_data = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_H:  load_data = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Half-words always land on lanes {addr[1],0} and {addr[1],0}+1.
  always_comb begin
    merged_word = word;
    case (size_e'(size))
      SIZE_B:  merged_word[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
      SIZE_H:  merged_word[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store FSM turning byte/half/word core requests into dmem word accesses (RMW for sub-word stores).
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  dmem_lsu_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dmem_lsu supports only DATA_WIDTH = 32");
  end

  state_e                state_q, state_d;
  logic                  we_q, uns_q, err_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q, merge_q;
  logic [31:0]           align_word, load_data, merged_word;
  logic                  accept;

  assign accept     = (state_q == IDLE) && bus.req_valid;
  // WRITE merges into the word captured in ACCESS; ACCESS works on live dmem data.
  assign align_word = (state_q == WRITE) ? merge_q : bus.mem_rdata;

  lsu_align u_align (
    .word        (align_word),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .uns         (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_d = is_misaligned(bus.req_size, bus.req_addr[1:0]) ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (!we_q) begin
          state_d = RESP;
        end else if (size_q == SIZE_W) begin
          bus.mem_we    = 1'b1;
          bus.mem_wdata = wdata_q;
          state_d       = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = merged_word;
        state_d       = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= is_misaligned(bus.req_size, bus.req_addr[1:0]);
        rdata_q <= '0;
      end
      if (state_q == ACCESS && !we_q)
        rdata_q <= load_data;
      if (state_q == ACCESS && we_q && size_q != SIZE_W)
        merge_q <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed requests push expectations, monitors check responses and dmem writes.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [64];
  bit preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4] <= 32'h12345680;
      mem[8] <= 32'hDEADBEEF;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];

  // Monitor: dmem writes and core responses, sampled on the falling edge.
  bit          seen = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  int          first_cyc;

  always @(negedge clk) begin : monitor
    rsp_t e;
    wr_t  w;
    if (reset_n) begin
      if (bus.mem_we) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("mem_addr", bus.mem_addr, w.addr);
          chk("mem_wdata", bus.mem_wdata, w.data);
        end
      end
      if (bus.rsp_valid) begin
        if (!seen) begin
          seen       = 1'b1;
          first_cyc  = cyc;
          held_rdata = bus.rsp_rdata;
          held_err   = bus.rsp_err;
        end else begin
          chk("rsp_rdata_stable", bus.rsp_rdata, held_rdata);
          chk("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
        end
        if (bus.rsp_ready) begin
          seen = 1'b0;
          chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
          if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("rsp_latency", 32'(first_cyc), 32'(e.due));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  // Latency L means rsp_valid is visible in the cycle after edge accept+L-1.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    wait_idle();
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rq.push_back('{rdata: exp_rdata, err: exp_err, due: cyc + lat - 1});
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] data);
    wq.push_back('{addr: addr, data: data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset_n = 1'b1;
    preload = 1'b0;

    // Word store then load.
    exp_write(32'h04, 32'hA5A5A5A5);
    do_req(1'b1, 2'd2, 1'b0, 32'h04, 32'hA5A5A5A5, 32'h0, 1'b0, 2);
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'hA5A5A5A5, 1'b0, 2);

    // Sign/zero extension.
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h00000080, 1'b0, 2);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h00001234, 1'b0, 2);

    // Sub-word read-modify-write.
    exp_write(32'h20, 32'hDEAD55EF);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000055, 32'h0, 1'b0, 3);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hDEAD55EF, 1'b0, 2);
    exp_write(32'h20, 32'hCAFE55EF);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234CAFE, 32'h0, 1'b0, 3);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, 2);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 2);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'hFFFFFFCA, 1'b0, 2);

    // Misaligned and illegal requests.
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h03, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1);

    // Backpressure with an intruding request that must be ignored.
    wait_idle();
    bus.rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'hA5A5A5A5, 1'b0, 2);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0BADF00D;
    chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;

    // Reset asserted in the WRITE cycle of a byte store.
    wait_idle();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h00000077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rmw_write_cycle_we", 32'(bus.mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_async_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_partial_write", mem[12], 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
